// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter with a TX FIFO, baud divisor and level IRQ.
// Optional parity bit (CTRL[2] = odd) when UART_TX_PARITY_EN is defined.
module uart_tx_dev #(
  parameter int unsigned      FIFO_DEPTH  = 4,
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(16)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_nx;
  logic             en, im, odd, ovf;
  logic [DIV_W-1:0] div, div_eff, d_lat, bcnt;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [1:0]       sel;
  logic             full, empty, busy, tick, can_pop, pop, push_req, push_ok;
  logic             unused_bits;

  assign sel         = Addr[1:0];
  assign unused_bits = ^{Addr[29:2], Din};
  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign div_eff     = (div == '0) ? DIV_W'(1) : div;
  assign tick        = (bcnt == '0);
  assign can_pop     = en && !empty;
  // STOP's last cycle can pop directly so back-to-back frames have no idle gap
  assign pop         = can_pop && ((state == IDLE) || (state == STOP && tick));
  assign push_req    = WE && (sel == 2'd2);
  assign push_ok     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      en  <= 1'b0;
      im  <= 1'b0;
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else if (WE) begin
      case (sel)
        2'd0: begin
          en <= Din[0];
          im <= Din[1];
        end
        2'd1: div <= Din[DIV_W-1:0];
        2'd2: if (full && !pop) ovf <= 1'b1;
        default: ovf <= 1'b0;
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset)                    odd <= 1'b0;
    else if (WE && sel == 2'd0)   odd <= Din[2];
  end
`else
  assign odd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= Din[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (can_pop) state_nx = START;
      START: if (tick) state_nx = DATA;
      DATA: if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
        state_nx = PARITY;
`else
        state_nx = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_nx = STOP;
`endif
      STOP:  if (tick) state_nx = can_pop ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Divisor is latched at frame start so DIV writes only affect the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      d_lat   <= DIV_W'(1);
      bcnt    <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      bit_idx <= '0;
      d_lat   <= div_eff;
      bcnt    <= div_eff - DIV_W'(1);
    end else if (state != IDLE) begin
      if (tick) begin
        bcnt <= d_lat - DIV_W'(1);
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        bcnt <= bcnt - DIV_W'(1);
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)    par_bit <= 1'b0;
    else if (pop) par_bit <= (^mem[rd_ptr]) ^ odd;
  end
`endif

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:   busy = 1'b0;
      START:  tx   = 1'b0;
      DATA:   tx   = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx   = par_bit;
`endif
      default: tx  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) IRQ <= 1'b0;
    else       IRQ <= im && empty && !busy;
  end

  always_comb begin
    Dout = '0;
    case (sel)
      2'd0: Dout[2:0]       = {odd, im, en};
      2'd1: Dout[DIV_W-1:0] = div;
      2'd3: Dout[7:0]       = {4'(count), ovf, empty, full, busy};
      default: Dout = '0;
    endcase
  end

endmodule
